// File: rtl/camera_button_ctrl.sv
// -----------------------------------------------------------------------------
// camera_button_ctrl
//
// Turns six raw push-buttons into single-cycle step pulses for the camera pose
// incrementers, with auto-repeat while a button is held.
//
// Per channel: two-flop synchronizer -> counter-based debouncer -> three-state
// repeat FSM (IDLE / DELAY / REPEAT) -> registered output pulse. Opposing
// pairs (left/right, up/down, rot_left/rot_right) suppress each other's pulses
// while both are held; the FSMs themselves keep running.
//
// Ports
//   clk            : system clock, all state on the rising edge
//   reset          : asynchronous, active-high reset
//   btn_*          : raw asynchronous button levels, active-high
//   left .. rot_right : registered single-cycle step pulses
//   held[5:0]      : registered debounced levels
//                    {rot_right, rot_left, down, up, right, left}
// -----------------------------------------------------------------------------
module camera_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned REPEAT_DELAY    = 26000000,
    parameter int unsigned REPEAT_PERIOD   = 6500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_rot_left,
    input  logic       btn_rot_right,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic       rot_left,
    output logic       rot_right,
    output logic [5:0] held
);

    localparam int CW = 25;
    localparam int NCH = 6;

    // Terminal counts: the action fires in the cycle the counter holds N-1.
    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 32'd1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    logic [NCH-1:0] btn_s;
    logic [NCH-1:0] sync1_q, sync2_q;
    logic [NCH-1:0] level_q, level_d;
    logic [CW-1:0]  deb_cnt_q [NCH];
    logic [CW-1:0]  deb_cnt_d [NCH];
    state_e         state_q   [NCH];
    state_e         state_d   [NCH];
    logic [CW-1:0]  rep_cnt_q [NCH];
    logic [CW-1:0]  rep_cnt_d [NCH];
    logic [NCH-1:0] raw_q, raw_d;
    logic [NCH-1:0] pulse_q, pulse_d;
    logic [NCH-1:0] held_q;
    logic [2:0]     pair_both_s;
    logic [NCH-1:0] mask_s;

    assign btn_s = {btn_rot_right, btn_rot_left, btn_down, btn_up, btn_right, btn_left};

    // Two-flop synchronizer for every raw button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 6'b000000;
            sync2_q <= 6'b000000;
        end else begin
            sync1_q <= btn_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: count consecutive samples that disagree with the
    // debounced level, flip the level once enough have been seen.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NCH; i++) begin
            deb_cnt_d[i] = {CW{1'b0}};
            if (sync2_q[i] == level_q[i]) begin
                deb_cnt_d[i] = {CW{1'b0}};
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                level_d[i]   = ~level_q[i];
                deb_cnt_d[i] = {CW{1'b0}};
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 25'd1;
            end
        end
    end

    // Repeat FSM next-state and raw pulse generation for every channel.
    // IDLE only ever sees a high level on the debounced rising edge, because
    // any falling edge forces the FSM back to IDLE.
    always_comb begin
        raw_d = 6'b000000;
        for (int i = 0; i < NCH; i++) begin
            state_d[i]   = state_q[i];
            rep_cnt_d[i] = rep_cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    rep_cnt_d[i] = {CW{1'b0}};
                    if (level_q[i]) begin
                        state_d[i] = ST_DELAY;
                        raw_d[i]   = 1'b1;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (!level_q[i]) begin
                        state_d[i]   = ST_IDLE;
                        rep_cnt_d[i] = {CW{1'b0}};
                    end else if (rep_cnt_q[i] == DELAY_LAST) begin
                        state_d[i]   = ST_REPEAT;
                        rep_cnt_d[i] = {CW{1'b0}};
                        raw_d[i]     = 1'b1;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + 25'd1;
                    end
                end
                ST_REPEAT: begin
                    if (!level_q[i]) begin
                        state_d[i]   = ST_IDLE;
                        rep_cnt_d[i] = {CW{1'b0}};
                    end else if (rep_cnt_q[i] == PERIOD_LAST) begin
                        rep_cnt_d[i] = {CW{1'b0}};
                        raw_d[i]     = 1'b1;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + 25'd1;
                    end
                end
                default: begin
                    state_d[i]   = ST_IDLE;
                    rep_cnt_d[i] = {CW{1'b0}};
                end
            endcase
        end
    end

    // Opposing-pair suppression uses the same debounced levels that drive held.
    always_comb begin
        pair_both_s = {level_q[5] & level_q[4], level_q[3] & level_q[2], level_q[1] & level_q[0]};
        mask_s      = {{2{pair_both_s[2]}}, {2{pair_both_s[1]}}, {2{pair_both_s[0]}}};
        pulse_d     = raw_q & ~mask_s;
    end

    // Debounce, FSM, raw pulse and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 6'b000000;
            raw_q   <= 6'b000000;
            pulse_q <= 6'b000000;
            held_q  <= 6'b000000;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt_q[i] <= {CW{1'b0}};
                rep_cnt_q[i] <= {CW{1'b0}};
                state_q[i]   <= ST_IDLE;
            end
        end else begin
            level_q <= level_d;
            raw_q   <= raw_d;
            pulse_q <= pulse_d;
            held_q  <= level_q;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    assign left      = pulse_q[0];
    assign right     = pulse_q[1];
    assign up        = pulse_q[2];
    assign down      = pulse_q[3];
    assign rot_left  = pulse_q[4];
    assign rot_right = pulse_q[5];
    assign held      = held_q;

endmodule

// File: tb/tb_camera_button_ctrl.sv
// -----------------------------------------------------------------------------
// tb_camera_button_ctrl
//
// Scoreboard bench: a behavioural model, stepped on every clock edge, pushes
// each expected pulse vector into a queue; a monitor on the falling edge pops
// and compares whenever the DUT shows a pulse or one is due. Directed scenarios
// with fixed expected pulse/held timelines run first, then randomized button
// and reset traffic.
// -----------------------------------------------------------------------------
module tb_camera_button_ctrl;

    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int MAXC = 8192;

    logic       clk;
    logic       reset;
    logic [5:0] btn_v;
    logic       p_left, p_right, p_up, p_down, p_rot_left, p_rot_right;
    logic [5:0] held;

    camera_button_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left     (btn_v[0]),
        .btn_right    (btn_v[1]),
        .btn_up       (btn_v[2]),
        .btn_down     (btn_v[3]),
        .btn_rot_left (btn_v[4]),
        .btn_rot_right(btn_v[5]),
        .left         (p_left),
        .right        (p_right),
        .up           (p_up),
        .down         (p_down),
        .rot_left     (p_rot_left),
        .rot_right    (p_rot_right),
        .held         (held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = -1;
    int   seg_start = 0;
    logic [5:0] pulse_log [MAXC];
    logic [5:0] held_log  [MAXC];

    // ---------------- behavioural reference model ----------------
    // Level: flips after DEB consecutive disagreeing synchronized samples.
    // Pulses: at hold age 1, then at age 1+RD+k*RP, while the level stays high.
    logic [5:0] m_s1 = 6'b0, m_s2 = 6'b0, m_level = 6'b0;
    logic [5:0] m_raw = 6'b0, m_out = 6'b0, m_held = 6'b0;
    int         m_cnt   [6];
    int         m_trise [6];

    task automatic model_step(input logic [5:0] b, input logic r);
        logic [5:0] nraw;
        logic [5:0] mask;
        int d;
        cyc++;
        if (r) begin
            m_s1 = 6'b0; m_s2 = 6'b0; m_level = 6'b0;
            m_raw = 6'b0; m_out = 6'b0; m_held = 6'b0;
            for (int i = 0; i < 6; i++) begin
                m_cnt[i] = 0;
                m_trise[i] = 0;
            end
        end else begin
            mask = 6'b0;
            for (int p = 0; p < 3; p++) begin
                if (m_level[2*p] && m_level[2*p+1]) begin
                    mask[2*p]   = 1'b1;
                    mask[2*p+1] = 1'b1;
                end
            end
            m_out  = m_raw & ~mask;
            m_held = m_level;
            nraw = 6'b0;
            for (int i = 0; i < 6; i++) begin
                d = cyc - m_trise[i];
                if (m_level[i] && (d == 1 || (d > RD && ((d - 1 - RD) % RP) == 0)))
                    nraw[i] = 1'b1;
            end
            for (int i = 0; i < 6; i++) begin
                if (m_s2[i] != m_level[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEB) begin
                        m_level[i] = ~m_level[i];
                        m_cnt[i] = 0;
                        if (m_level[i]) m_trise[i] = cyc;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
            end
            m_raw = nraw;
            m_s2  = m_s1;
            m_s1  = b;
        end
        if (m_out != 6'b0) exp_q.push_back('{cyc: cyc, vec: m_out});
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            m_cnt[i] = 0;
            m_trise[i] = 0;
        end
        forever begin
            @(posedge clk);
            model_step(btn_v, reset);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [5:0] dut_p;
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc >= 0) begin
                dut_p = {p_rot_right, p_rot_left, p_down, p_up, p_right, p_left};
                if (cyc < MAXC) begin
                    pulse_log[cyc] = dut_p;
                    held_log[cyc]  = held;
                end
                checks++;
                if (held !== m_held)
                    $display("FAIL held cyc=%0d actual=%b required=%b", cyc, held, m_held);
                else
                    passes++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (dut_p !== e.vec)
                        $display("FAIL pulse cyc=%0d actual=%b required=%b", cyc, dut_p, e.vec);
                    else
                        passes++;
                end else if (dut_p !== 6'b0) begin
                    checks++;
                    $display("FAIL unexpected_pulse cyc=%0d actual=%b required=000000", cyc, dut_p);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present (b, r) for n consecutive clock edges.
    task automatic run(input logic [5:0] b, input logic r, input int n);
        logic was_reset;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) seg_start = cyc + 1;
            was_reset = reset;
            btn_v = b;
            reset = r;
            if (r && !was_reset) begin
                #1;
                checks++;
                if ({p_rot_right, p_rot_left, p_down, p_up, p_right, p_left, held} !== 12'b0)
                    $display("FAIL reset_immediate cyc=%0d actual=%b held=%b required=0",
                             cyc, {p_rot_right, p_rot_left, p_down, p_up, p_right, p_left}, held);
                else
                    passes++;
            end
        end
    endtask

    // Compare the per-offset timeline of one channel against a fixed mask.
    task automatic check_window(input string name, input int s, input int len, input int ch,
                                input logic use_held, input logic [63:0] req);
        logic [63:0] got;
        got = 64'd0;
        for (int k = 0; k < len; k++)
            got[k] = use_held ? held_log[s+k][ch] : pulse_log[s+k][ch];
        checks++;
        if (got !== req)
            $display("FAIL %s actual=%h required=%h", name, got, req);
        else
            passes++;
    endtask

    localparam logic [5:0] B_L  = 6'b000001;
    localparam logic [5:0] B_R  = 6'b000010;
    localparam logic [5:0] B_U  = 6'b000100;
    localparam logic [5:0] B_D  = 6'b001000;
    localparam logic [5:0] B_RL = 6'b010000;
    localparam logic [5:0] B_RR = 6'b100000;

    initial begin
        int s;
        int len;
        logic [5:0] b;
        btn_v = 6'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        run(6'b0, 1'b1, 3);
        run(6'b0, 1'b0, 10);

        // Single hold with repeat.
        run(B_R, 1'b0, 50); s = seg_start;
        run(6'b0, 1'b0, 25);
        check_window("right_hold_pulses", s, 50, 1, 1'b0,
                     (64'd1 << 7) | (64'd1 << 27) | (64'd1 << 35) | (64'd1 << 43));
        check_window("right_hold_level", s, 50, 1, 1'b1,
                     ((64'd1 << 50) - 64'd1) & ~((64'd1 << 6) - 64'd1));

        // Short glitch.
        run(B_U, 1'b0, 3); s = seg_start;
        run(6'b0, 1'b0, 20);
        check_window("glitch_pulses", s, 20, 2, 1'b0, 64'd0);
        check_window("glitch_level", s, 20, 2, 1'b1, 64'd0);

        // Opposing pair held together.
        run(B_L, 1'b0, 10); s = seg_start;
        run(B_L | B_R, 1'b0, 40);
        run(6'b0, 1'b0, 25);
        check_window("pair_left", s, 50, 0, 1'b0, 64'd1 << 7);
        check_window("pair_right", s, 50, 1, 1'b0, 64'd0);

        // Independent channels pulse together.
        run(B_D | B_RL, 1'b0, 40); s = seg_start;
        run(6'b0, 1'b0, 25);
        check_window("indep_down", s, 40, 3, 1'b0,
                     (64'd1 << 7) | (64'd1 << 27) | (64'd1 << 35));
        check_window("indep_rot_left", s, 40, 4, 1'b0,
                     (64'd1 << 7) | (64'd1 << 27) | (64'd1 << 35));

        // Reset during DELAY while held.
        run(B_L, 1'b0, 15); s = seg_start;
        run(B_L, 1'b1, 2);
        run(B_L, 1'b0, 23);
        run(6'b0, 1'b0, 25);
        check_window("reset_rehold_left", s, 40, 0, 1'b0, (64'd1 << 7) | (64'd1 << 24));

        // Hold then release.
        run(B_RR, 1'b0, 30); s = seg_start;
        run(6'b0, 1'b0, 25);
        check_window("release_level", s, 50, 5, 1'b1,
                     ((64'd1 << 36) - 64'd1) & ~((64'd1 << 6) - 64'd1));

        // Randomized traffic.
        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                run(6'($urandom_range(0, 63)), 1'b1, $urandom_range(1, 2));
            end else begin
                b   = 6'($urandom_range(0, 63));
                len = $urandom_range(1, 45);
                run(b, 1'b0, len);
            end
        end
        run(6'b0, 1'b0, 30);

        checks++;
        if (exp_q.size() != 0)
            $display("FAIL leftover_expected actual=%0d required=0", exp_q.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
